// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: registered {pc, inst} FIFO with valid/ready and flush.
// Optional performance counters are enabled by defining IF_ID_QUEUE_PERF_EN.
module if_id_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_inst,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_inst,
  output logic [XLEN-1:0]        out_pc_plus4,
  output logic [$clog2(DEPTH):0] count
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [15:0]            flush_count
`endif
);

  localparam int unsigned      AW   = $clog2(DEPTH);
  localparam logic [AW:0]      Full = (AW + 1)'(DEPTH);
  localparam logic [XLEN-1:0]  Nop  = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  // in_ready looks only at state, so a full queue never takes a push even if it pops.
  assign in_ready  = (r_count != Full);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; unread slots are never exposed.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
    end
  end

  always_comb begin
    out_pc   = '0;
    out_inst = Nop;
    if (out_valid) begin
      out_pc   = r_pc_mem[r_rd_ptr];
      out_inst = r_inst_mem[r_rd_ptr];
    end
  end

  assign out_pc_plus4 = out_pc + XLEN'(4);

`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (in_valid && !in_ready && !flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (flush && (r_count != '0) && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised + directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        in_pc;
  logic [XLEN-1:0]        in_inst;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [XLEN-1:0]        out_inst;
  logic [XLEN-1:0]        out_pc_plus4;
  logic [$clog2(DEPTH):0] count;
`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0]            stall_cycles;
  logic [15:0]            flush_count;
`endif

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_pc_plus4 (out_pc_plus4),
    .count        (count)
`ifdef IF_ID_QUEUE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: entries as a plain FIFO of {pc, inst}.
  logic [2*XLEN-1:0] mq[$];
  longint unsigned   m_stall = 0;
  longint unsigned   m_flush = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit push, pop;
    push = in_valid && (mq.size() != DEPTH);
    pop  = out_ready && (mq.size() != 0);
    if (in_valid && mq.size() == DEPTH && !flush && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (flush && mq.size() != 0 && m_flush != 64'hFFFF) m_flush++;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({in_pc, in_inst});
    end
  endtask

  task automatic step(input bit v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                      input bit rdy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic [XLEN-1:0] epc, einst, ep4;
      if (mq.size() != 0) begin
        epc   = mq[0][2*XLEN-1:XLEN];
        einst = mq[0][XLEN-1:0];
      end else begin
        epc   = '0;
        einst = 32'h0000_0013;
      end
      ep4 = epc + 32'd4;
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_pc", 64'(out_pc), 64'(epc));
      chk("out_inst", 64'(out_inst), 64'(einst));
      chk("out_pc_plus4", 64'(out_pc_plus4), 64'(ep4));
`ifdef IF_ID_QUEUE_PERF_EN
      chk("stall_cycles", 64'(stall_cycles), m_stall);
      chk("flush_count", 64'(flush_count), m_flush);
`endif
    end
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_pc = '0; in_inst = '0; out_ready = 0; flush = 0;
    #12 rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_inst", 64'(out_inst), 64'h13);
    chk("rst_plus4", 64'(out_pc_plus4), 64'd4);

    // Single pass
    step(1, 32'h100, 32'h0050_0093, 1, 0);
    chk("sp_valid", 64'(out_valid), 64'd1);
    chk("sp_pc", 64'(out_pc), 64'h100);
    chk("sp_plus4", 64'(out_pc_plus4), 64'h104);
    chk("sp_inst", 64'(out_inst), 64'h0050_0093);
    step(0, 0, 0, 1, 0);
    chk("sp_empty", 64'(out_valid), 64'd0);

    // Back-pressure: third push is refused while full
    step(1, 32'h0, 32'h11, 0, 0);
    step(1, 32'h4, 32'h22, 0, 0);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_count", 64'(count), 64'd2);
    step(1, 32'h8, 32'h33, 0, 0);
    chk("bp_hold_count", 64'(count), 64'd2);
    chk("bp_hold_pc", 64'(out_pc), 64'h0);
    step(1, 32'h8, 32'h33, 1, 0);
    chk("bp_pop1_pc", 64'(out_pc), 64'h4);
    chk("bp_pop1_count", 64'(count), 64'd1);
    step(1, 32'h8, 32'h33, 1, 0);
    chk("bp_pop2_pc", 64'(out_pc), 64'h8);
    step(0, 0, 0, 1, 0);
    chk("bp_drained", 64'(count), 64'd0);

    // Full throughput across pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(4 * i), 32'(i + 32'h1000), 1, 0);
      chk("tp_count", 64'(count), 64'd1);
      chk("tp_pc", 64'(out_pc), 64'(4 * i));
    end
    step(0, 0, 0, 1, 0);

    // Flush beats a same-cycle push and pop
    step(1, 32'h300, 32'h1, 0, 0);
    step(1, 32'h304, 32'h2, 0, 0);
    step(1, 32'h200, 32'h3, 1, 1);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    step(0, 0, 0, 1, 0);
    chk("fl_no_200", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-cycle
    step(1, 32'h40, 32'h5, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_out_inst", 64'(out_inst), 64'h13);
    chk("ar_plus4", 64'(out_pc_plus4), 64'd4);
    mq.delete(); m_stall = 0; m_flush = 0;
    rst = 1'b0;

    // Pc overflow, then stall counting while full
    step(1, 32'hFFFF_FFFC, 32'h7, 0, 0);
    chk("ov_plus4", 64'(out_pc_plus4), 64'h0);
    step(1, 32'h10, 32'h8, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h14, 32'h9, 0, 0);
`ifdef IF_ID_QUEUE_PERF_EN
    chk("perf_stall5", 64'(stall_cycles), 64'd5);
    step(0, 0, 0, 0, 1);
    chk("perf_flush1", 64'(flush_count), 64'd1);
    step(0, 0, 0, 0, 1);
    chk("perf_flush_empty", 64'(flush_count), 64'd1);
`endif
    step(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom, $urandom,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
